// File: rtl/asrv32_muldiv_pkg.sv
// asrv32 multiply/divide unit: shared opcodes, FSM states
// and operand-signedness helpers.
package asrv32_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV, REM
  function automatic logic md_op1_signed(
    input logic [2:0] op
  );
    return (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV)  || (op == MD_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV, REM
  function automatic logic md_op2_signed(
    input logic [2:0] op
  );
    return (op == MD_MULH) || (op == MD_DIV) ||
           (op == MD_REM);
  endfunction

endpackage

// File: rtl/asrv32_muldiv_if.sv
// asrv32 multiply/divide request/response bundle.
// Execute stage is the master, the muldiv unit the slave.
interface asrv32_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            ready;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, op1, op2, flush,
    input  ready, valid, result
  );

  modport slave (
    input  start, op, op1, op2, flush,
    output ready, valid, result
  );
endinterface

// File: rtl/asrv32_muldiv_step.sv
// asrv32 muldiv: one radix-2 iteration, shared by
// shift-add multiply and restoring shift-subtract divide.
module asrv32_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_mq,
  input  logic [XLEN-1:0] i_opd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_mq
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  // mul: {acc,mq} += opd when mq[0], then shift right.
  // div: shift {acc,mq} left, subtract divisor if it fits.
  always_comb begin
    w_sum = {1'b0, i_acc} +
            (i_mq[0] ? {1'b0, i_opd} : '0);
    w_shl = {i_acc, i_mq[XLEN-1]};
    w_ge  = (w_shl >= {1'b0, i_opd});
    w_sub = XLEN'(w_shl - {1'b0, i_opd});
    o_acc = w_sum[XLEN:1];
    o_mq  = {w_sum[0], i_mq[XLEN-1:1]};
    if (i_div) begin
      if (w_ge) begin
        o_acc = w_sub;
        o_mq  = {i_mq[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_shl[XLEN-1:0];
        o_mq  = {i_mq[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/asrv32_muldiv.sv
// asrv32 iterative RV32M multiply/divide unit.
// XLEN-cycle radix-2 core with single-cycle special cases.
module asrv32_muldiv
  import asrv32_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  asrv32_muldiv_if.slave io_md
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_V =
    {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mq;
  logic [XLEN-1:0] r_opd;
  logic [CNT_W-1:0] r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_ready;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  logic            w_div;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_dz;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN-1:0] w_acc_n;
  logic [XLEN-1:0] w_mq_n;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_q_s;
  logic [XLEN-1:0] w_r_s;
  logic [XLEN-1:0] w_final;

  assign io_md.ready  = r_ready;
  assign io_md.valid  = r_valid;
  assign io_md.result = r_result;

  // request decode: magnitudes, signs and special cases
  always_comb begin
    w_div  = io_md.op[2];
    w_s1   = io_md.op1[XLEN-1] & md_op1_signed(io_md.op);
    w_s2   = io_md.op2[XLEN-1] & md_op2_signed(io_md.op);
    w_abs1 = w_s1 ? -io_md.op1 : io_md.op1;
    w_abs2 = w_s2 ? -io_md.op2 : io_md.op2;
    w_dz   = w_div && (io_md.op2 == '0);
    w_ovf  = ((io_md.op == MD_DIV) ||
              (io_md.op == MD_REM)) &&
             (io_md.op1 == MIN_V) &&
             (io_md.op2 == {XLEN{1'b1}});
    w_fast = w_dz | w_ovf;
    w_fast_res = '0;
    if (w_dz)
      w_fast_res = io_md.op[1] ? io_md.op1 : '1;
    else if (w_ovf)
      w_fast_res = io_md.op[1] ? '0 : MIN_V;
  end

  asrv32_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_mq  (r_mq),
    .i_opd (r_opd),
    .o_acc (w_acc_n),
    .o_mq  (w_mq_n)
  );

  // sign correction and result select on the last step
  always_comb begin
    w_prod   = {w_acc_n, w_mq_n};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_q_s    = r_neg_q ? -w_mq_n : w_mq_n;
    w_r_s    = r_neg_r ? -w_acc_n : w_acc_n;
    w_final  = '0;
    unique case (r_op)
      MD_MUL:
        w_final = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:
        w_final = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:
        w_final = w_q_s;
      default:
        w_final = w_r_s;
    endcase
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else if (io_md.flush) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          if (io_md.start) begin
            r_op    <= io_md.op;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(XLEN);
            if (w_div) begin
              r_mq  <= w_abs1;
              r_opd <= w_abs2;
            end else begin
              r_mq  <= w_abs2;
              r_opd <= w_abs1;
            end
            if (w_fast) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= w_fast_res;
            end else begin
              r_state <= S_CALC;
              r_ready <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_n;
          r_mq  <= w_mq_n;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b1;
            r_result <= w_final;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_muldiv.sv
// asrv32_muldiv bench: directed RV32M vectors against an
// arithmetic reference model with a latency scoreboard.
module tb_asrv32_muldiv;
  import asrv32_muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [31:0] last_res = '0;
  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  asrv32_muldiv_if #(.XLEN(XLEN)) md();

  asrv32_muldiv #(.XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_md (md)
  );

  function automatic logic [31:0] model(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sa, sb;
    longint p;
    logic [63:0] u;
    logic [31:0] r;
    sa = a;
    sb = b;
    r = '0;
    case (op)
      MD_MUL: begin
        u = {32'b0, a} * {32'b0, b};
        r = u[31:0];
      end
      MD_MULH: begin
        p = longint'(sa) * longint'(sb);
        u = p;
        r = u[63:32];
      end
      MD_MULHSU: begin
        p = longint'(sa) * longint'({32'b0, b});
        u = p;
        r = u[63:32];
      end
      MD_MULHU: begin
        u = {32'b0, a} * {32'b0, b};
        r = u[63:32];
      end
      MD_DIV: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          r = a;
        else r = 32'(sa / sb);
      end
      MD_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return op[2] && ((b == 0) || (!op[0] &&
      a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // scoreboard: every o_valid must match the oldest request
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (md.valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: result %h cyc %0d",
                   md.result, cyc);
        end else begin
          e = q.pop_front();
          if (md.result !== e.res) begin
            errors++;
            $display("FAIL result: got %h expected %h",
                     md.result, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency: valid cyc %0d expected %0d",
                     cyc, e.cyc);
          end
          last_res = e.res;
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: expected at cyc %0d",
                 q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // called at a negedge; holds start until accepted, then
  // returns at the next negedge with start low and junk operands
  task automatic issue(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n;
    exp_t e;
    n = 0;
    md.start = 1'b1;
    md.op    = op;
    md.op1   = a;
    md.op2   = b;
    while (!md.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!md.ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d", op);
    end else begin
      e.res = model(op, a, b);
      e.cyc = cyc + (is_fast(op, a, b) ? 1 : XLEN + 1);
      q.push_back(e);
    end
    @(negedge clk);
    md.start = 1'b0;
    md.op    = 3'($urandom);
    md.op1   = $urandom;
    md.op2   = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    md.start = 1'b0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pending", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h80000000;
      3: v = 32'($urandom_range(0, 9));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst      = 1'b1;
    md.start = 1'b0;
    md.flush = 1'b0;
    md.op    = '0;
    md.op1   = '0;
    md.op2   = '0;

    // model pinned by hand-computed values
    check("m_mul", model(MD_MUL, 7, -3), 32'hFFFFFFEB);
    check("m_mulh", model(MD_MULH, 32'h80000000,
          32'h80000000), 32'h40000000);
    check("m_mulhsu", model(MD_MULHSU, 32'hFFFFFFFF,
          32'hFFFFFFFF), 32'hFFFFFFFF);
    check("m_mulhu", model(MD_MULHU, 32'hFFFFFFFF,
          32'hFFFFFFFF), 32'hFFFFFFFE);
    check("m_div_ovf", model(MD_DIV, 32'h80000000,
          -1), 32'h80000000);
    check("m_rem_ovf", model(MD_REM, 32'h80000000,
          -1), 32'h0);
    check("m_divu0", model(MD_DIVU, 1234, 0), 32'hFFFFFFFF);
    check("m_remu0", model(MD_REMU, 5, 0), 32'h5);
    check("m_div", model(MD_DIV, -7, 2), 32'hFFFFFFFD);
    check("m_rem", model(MD_REM, -7, 2), 32'hFFFFFFFF);

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(md.ready), 32'h1);
    check("rst_valid", 32'(md.valid), 32'h0);
    check("rst_result", md.result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // MUL with ready low during CALC
    issue(MD_MUL, 7, -3);
    check("calc_ready0", 32'(md.ready), 32'h0);
    repeat (5) @(negedge clk);
    check("calc_ready5", 32'(md.ready), 32'h0);
    drain();

    // directed vectors, including the fast path
    issue(MD_MULH, 32'h80000000, 32'h80000000); drain();
    issue(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF); drain();
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF); drain();
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF); drain();
    issue(MD_REM, 32'h80000000, 32'hFFFFFFFF); drain();
    issue(MD_DIVU, 32'h12345678, 0); drain();
    issue(MD_REMU, 5, 0); drain();
    issue(MD_DIV, -7, 2); drain();
    issue(MD_REM, -7, 2); drain();
    issue(MD_DIV, 100, 0); drain();
    issue(MD_REM, -9, 0); drain();

    // back-to-back: second request held through CALC,
    // accepted in the DONE cycle
    issue(MD_MUL, 123, 456);
    issue(MD_DIVU, 1000, 7);
    issue(MD_REMU, 1000, 0);
    issue(MD_MULH, -5, 3);
    drain();

    // flush in the 10th CALC cycle
    issue(MD_MUL, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    md.flush = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    md.flush = 1'b0;
    check("flush_ready", 32'(md.ready), 32'h1);
    check("flush_valid", 32'(md.valid), 32'h0);
    check("flush_result", md.result, last_res);
    repeat (XLEN + 5) @(negedge clk);

    // flush and start together: request dropped
    md.start = 1'b1;
    md.flush = 1'b1;
    md.op    = MD_MUL;
    md.op1   = 3;
    md.op2   = 4;
    @(negedge clk);
    md.start = 1'b0;
    md.flush = 1'b0;
    check("fs_ready", 32'(md.ready), 32'h1);
    check("fs_result", md.result, last_res);
    repeat (XLEN + 5) @(negedge clk);

    // reset mid-CALC
    issue(MD_DIVU, 32'hFFFF0000, 3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    void'(q.pop_back());
    #1;
    check("arst_ready", 32'(md.ready), 32'h1);
    check("arst_valid", 32'(md.valid), 32'h0);
    check("arst_result", md.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    repeat (XLEN + 5) @(negedge clk);

    // random chained ops over all opcodes
    for (int i = 0; i < 200; i++)
      issue(3'($urandom), pick(), pick());
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
